// File: rtl/cla_adder_arbiter.sv
// Round-robin front end that time-shares one 16-bit carry-look-ahead adder among N_REQ clients.
// Each grant latches one operand pair; the registered result returns two cycles after the request.
module cla_adder_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic [WIDTH:0]         sum,
  output logic [15:0]            op_count
);

  localparam int unsigned NGrp = WIDTH / 4;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]    tag_q, tag_d, last_q, last_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [WIDTH:0]     sum_q, sum_d;
  logic [15:0]        op_count_q, op_count_d;

  // Shared adder: 4-bit lookahead groups chained by a group-level lookahead carry.
  logic [WIDTH-1:0] g, p;
  logic [NGrp-1:0]  grp_g, grp_p;
  logic [NGrp:0]    grp_c;
  logic [WIDTH:0]   c;
  logic [WIDTH:0]   add_s;

  always_comb begin
    g = a_q & b_q;
    p = a_q ^ b_q;
    c = '0;
    grp_c = '0;
    for (int j = 0; j < NGrp; j++) begin
      grp_p[j] = &p[4*j +: 4];
      grp_g[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
                 (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
    end
    for (int j = 0; j < NGrp; j++) begin
      c[4*j] = grp_c[j];
      for (int b = 0; b < 3; b++) begin
        c[4*j+b+1] = g[4*j+b] | (p[4*j+b] & c[4*j+b]);
      end
    end
    c[WIDTH] = grp_c[NGrp];
    add_s = {c[WIDTH], p ^ c[WIDTH-1:0]};
  end

  // Scan last+1, last+2, ... so the most recent winner has lowest priority.
  logic            win_vld;
  logic [ID_W-1:0] win_id, scan_idx;

  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((32'(last_q) + k) % N_REQ);
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_id  = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    done_id_d  = done_id_q;
    sum_d      = sum_q;
    op_count_d = op_count_q;
    unique case (state_q)
      StIdle, StDone: begin
        done_d = 1'b0;
        if (win_vld) begin
          a_d     = op_a[32'(win_id)*WIDTH +: WIDTH];
          b_d     = op_b[32'(win_id)*WIDTH +: WIDTH];
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
          tag_d   = win_id;
          last_d  = win_id;
          state_d = StExec;
        end else begin
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      StExec: begin
        sum_d      = add_s;
        done_d     = 1'b1;
        done_id_d  = tag_q;
        op_count_d = op_count_q + 16'd1;
        gnt_d      = '0;
        state_d    = StDone;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      last_q     <= ID_W'(N_REQ - 1);
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      sum_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      sum_q      <= sum_d;
      op_count_q <= op_count_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign sum      = sum_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Bench for cla_adder_arbiter: directed scenarios plus random traffic, all checked against a
// transaction-level model (rotating priority, plain integer addition, modular op counter).
module tb_cla_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] op_a, op_b;
  logic [3:0]  gnt;
  logic        busy, done;
  logic [1:0]  done_id;
  logic [16:0] sum;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  cla_adder_arbiter #(.N_REQ(4), .ID_W(2), .WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op_a     (op_a),
    .op_b     (op_b),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .sum      (sum),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0]  e_gnt;
  logic        e_busy, e_done;
  logic [1:0]  e_id;
  logic [16:0] e_sum;
  logic [15:0] e_cnt;
  int          m_last;
  bit          m_exec;
  int          m_pid;
  logic [16:0] m_psum;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Predict what the coming clock edge produces from the inputs now applied.
  task automatic model_edge();
    int w;
    if (rst) begin
      e_gnt = '0; e_busy = 1'b0; e_done = 1'b0; e_id = '0; e_sum = '0; e_cnt = '0;
      m_last = 3; m_exec = 1'b0;
    end else if (m_exec) begin
      e_done = 1'b1; e_id = 2'(m_pid); e_sum = m_psum; e_cnt = e_cnt + 16'd1;
      e_gnt = '0; e_busy = 1'b1; m_exec = 1'b0;
    end else begin
      e_done = 1'b0;
      w = pick(req, m_last);
      if (w >= 0) begin
        e_gnt  = 4'b0001 << w;
        e_busy = 1'b1;
        m_last = w;
        m_pid  = w;
        m_psum = {1'b0, op_a[w*16 +: 16]} + {1'b0, op_b[w*16 +: 16]};
        m_exec = 1'b1;
      end else begin
        e_gnt  = '0;
        e_busy = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [39:0] obs();
    return {gnt, busy, done, done_id, sum, op_count};
  endfunction

  function automatic logic [39:0] expv();
    return {e_gnt, e_busy, e_done, e_id, e_sum, e_cnt};
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    op_a[i*16 +: 16] = a;
    op_b[i*16 +: 16] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    cycle();
    cycle();
    n_tests++;
    if (obs() !== 40'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs(), 40'h0);
    end
    rst = 1'b0; req = '0;
    cycle();
    n_tests++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL reset_idle: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_single();
    set_op(0, 16'hFFFF, 16'h0001); req = 4'b0001;
    cycle();
    n_tests++;
    if (obs() !== expv() || gnt !== 4'b0001) begin
      n_fail++; $display("FAIL single_gnt: got %h expected %h", obs(), expv());
    end
    req = '0;
    cycle();
    n_tests++;
    if (obs() !== expv() || {done, done_id, sum, op_count} !== {1'b1, 2'd0, 17'h10000, 16'd1}) begin
      n_fail++; $display("FAIL single_done: got %h expected %h", obs(), expv());
    end
    cycle();
    n_tests++;
    if (obs() !== expv() || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  want_g;
    logic [16:0] want_s;
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 16'($urandom), 16'($urandom));
    req = 4'hF;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL rr_model c%0d: got %h expected %h", c, obs(), expv());
      end
      n_tests++;
      if (c % 2 == 1) begin
        want_g = 4'b0001 << ((c - 1) / 2);
        if (gnt !== want_g) begin
          n_fail++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt, want_g);
        end
      end else begin
        want_s = {1'b0, op_a[(c/2-1)*16 +: 16]} + {1'b0, op_b[(c/2-1)*16 +: 16]};
        if (done !== 1'b1 || done_id !== 2'(c/2-1) || sum !== want_s) begin
          n_fail++; $display("FAIL rr_done c%0d: got id %0d sum %h expected id %0d sum %h",
                             c, done_id, sum, c/2-1, want_s);
        end
      end
    end
    req = '0; cycle(); cycle();
  endtask

  task automatic test_fairness();
    int since0 = 0;
    int since2 = 0;
    req = 4'b0101;
    for (int c = 1; c <= 16; c++) begin
      cycle();
      since0++; since2++;
      if (gnt[0]) since0 = 0;
      if (gnt[2]) since2 = 0;
      n_tests++;
      if (obs() !== expv() || since0 > 4 || since2 > 4) begin
        n_fail++; $display("FAIL fairness c%0d: got %h expected %h waits %0d %0d",
                           c, obs(), expv(), since0, since2);
      end
    end
    req = '0; cycle(); cycle();
  endtask

  task automatic test_reset_mid();
    set_op(1, 16'hDCD9, 16'h8A5F); req = 4'b0010;
    cycle();
    req = '0; rst = 1'b1;
    cycle();
    n_tests++;
    if (obs() !== 40'h0 || obs() !== expv()) begin
      n_fail++; $display("FAIL reset_mid: got %h expected %h", obs(), 40'h0);
    end
    rst = 1'b0; req = 4'b0010;
    cycle();
    n_tests++;
    if (obs() !== expv() || gnt !== 4'b0010 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_regrant: got %h expected %h", obs(), expv());
    end
    req = '0;
    cycle();
    n_tests++;
    if (obs() !== expv() || {done, done_id, sum, op_count} !== {1'b1, 2'd1, 17'h16738, 16'd1}) begin
      n_fail++; $display("FAIL reset_redone: got %h expected %h", obs(), expv());
    end
    cycle();
  endtask

  task automatic test_wrap();
    logic [15:0] want_c;
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    e_cnt = 16'hFFFE;
    for (int n = 0; n < 2; n++) begin
      set_op(2, 16'($urandom), 16'($urandom)); req = 4'b0100;
      cycle();
      req = '0;
      cycle();
      want_c = (n == 0) ? 16'hFFFF : 16'h0000;
      n_tests++;
      if (obs() !== expv() || op_count !== want_c ||
          sum !== {1'b0, op_a[47:32]} + {1'b0, op_b[47:32]}) begin
        n_fail++; $display("FAIL wrap%0d: got %h expected %h", n, obs(), expv());
      end
    end
    cycle();
  endtask

  task automatic test_pulse();
    set_op(3, 16'h1234, 16'hFEDC); req = 4'b1000;
    cycle();
    n_tests++;
    if (obs() !== expv() || gnt !== 4'b1000) begin
      n_fail++; $display("FAIL pulse_gnt: got %h expected %h", obs(), expv());
    end
    req = '0;
    cycle();
    n_tests++;
    if (obs() !== expv() || {done, done_id, sum} !== {1'b1, 2'd3, 17'h11110}) begin
      n_fail++; $display("FAIL pulse_done: got %h expected %h", obs(), expv());
    end
    cycle();
    req = 4'b0001;
    cycle();
    req = 4'b1000;
    cycle();
    req = '0;
    cycle();
    n_tests++;
    if (obs() !== expv() || gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pulse_exec_ignored: got %h expected %h", obs(), expv());
    end
    cycle();
    n_tests++;
    if (obs() !== expv() || done !== 1'b0) begin
      n_fail++; $display("FAIL pulse_no_done: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      rst  = ($urandom_range(0, 99) == 0);
      cycle();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random c%0d: got %h expected %h", c, obs(), expv());
      end
    end
    rst = 1'b0; req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; op_a = '0; op_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_reset_mid();
    test_wrap();
    test_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
